spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- SPI mode-0 serial-flash responder; the device end of the SoC's flash interface (o_flash_sclk/o_flash_cs_n/o_flash_mosi in, i_flash_miso out).
- Holds a byte-addressed memory loaded through a backdoor write port and answers READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05).
- Used as a synthesizable flash stand-in for SoC simulation and FPGA bring-up. Oversamples the SPI pins with the system clock.

Parameters:
- MEM_AW, 16, memory byte-address width; depth = 2**MEM_AW bytes.
- JEDEC_ID, 24'hEF4016, the three ID bytes returned MSB-first by 0x9F.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_sclk  input  1  SPI clock from the master (asynchronous to clk).
- i_cs_n  input  1  SPI chip select, active low.
- i_mosi  input  1  master-out data.
- o_miso  output  1  slave-out data.
- i_wr_en  input  1  backdoor byte write strobe.
- i_wr_addr  input  MEM_AW  backdoor write address.
- i_wr_data  input  8  backdoor write data.
- o_busy  output  1  high while a transaction is active.
- o_last_cmd  output  8  last command byte received.
- o_bad_cmd  output  1  one-cycle pulse on an unsupported command.

Behaviour:
- Reset values:
  - o_miso=0, o_busy=0, o_last_cmd=8'h00, o_bad_cmd=0.
  - FSM in IDLE; address and bit counters cleared.
  - Memory contents are not cleared.
- Synchronisation:
  - i_sclk, i_cs_n and i_mosi each pass through a 2-flop synchroniser.
  - Rise and fall of sclk are detected from the synchronised value and its 1-cycle delay.
  - The master's sclk period must be at least 4 clk periods. Latency from pin to action is 3 clk.
- Shifting:
  - MOSI is sampled on each detected sclk rise, MSB first.
  - MISO is updated on each detected sclk fall, MSB first.
- FSM states: IDLE, CMD, ADDR, DUMMY (feature only), DATA, ID, STAT, IGNORE.
- Transitions:
  - IDLE→CMD on synchronised cs_n falling; o_busy=1.
  - CMD: after 8 rises, latch o_last_cmd.
    - 0x03→ADDR.
    - 0x9F→ID.
    - 0x05→STAT.
    - Anything else→IGNORE, with o_bad_cmd pulsed for 1 clk.
  - ADDR: after 24 rises, the address is captured and truncated to MEM_AW LSBs. The memory read is issued on the next clk; data arrives 1 clk later. Then →DATA.
  - DATA: bit7 of the byte is driven on the first fall after the 24th address rise; one bit per fall follows.
    - After the 8th bit is shifted out, the address increments. It wraps from 2**MEM_AW-1 to 0.
    - The next byte is prefetched and its bit7 is driven on the following fall. The data stream is continuous and gap-free.
  - ID: shift out JEDEC_ID[23:16], [15:8], [7:0]. Afterwards o_miso=0 until cs_n rises.
  - STAT: return 8'h00 (never busy, WEL=0), repeated for as long as cs_n stays low.
  - IGNORE: o_miso=0 until cs_n rises.
- cs_n high (synchronised) in any state:
  - Next clk: →IDLE, o_miso=0, o_busy=0, bit counter cleared.
  - A partial byte is discarded. A partial address is not retained.
- Reset during an active transaction gives the same result as the reset values. The master must deassert then reassert cs_n to start a new command.
- Backdoor writes:
  - Accepted in any state, 1 clk, no stall.
  - A same-cycle read and write to the same address is read-first: the SPI side receives the old byte.
- o_miso is never tri-stated. The SoC wiring is point-to-point.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- When defined, command 0x0B is accepted: CMD→ADDR (24 bits)→DUMMY (8 rises, MOSI ignored, o_miso=0)→DATA. Data timing relative to the last dummy rise matches READ's timing relative to the last address rise.
- When not defined, 0x0B goes to IGNORE and pulses o_bad_cmd. No DUMMY state or counter is synthesised.

Test Plan:
- Backdoor-load bytes 0x00..0x07 with 0x11,0x22,...,0x88; drive cs_n low, send 0x03 000002, clock 24 bits → MISO returns 0x33,0x44,0x55; o_last_cmd=0x03; o_busy=1 until cs_n high +3 clk.
- Load byte 0xFFFF=0xA5 and byte 0x0000=0x5A (MEM_AW=16); send 0x03 00FFFF and read 2 bytes → 0xA5 then 0x5A (wrap). Send 0x03 01FFFF → 0xA5 (upper address bits truncated).
- Send 0x9F then 32 clocks → 0xEF,0x40,0x16,0x00. Send 0x05 and 16 clocks → 0x00,0x00.
- Send 0x0B without the macro → o_bad_cmd high exactly 1 clk, MISO stays 0. With SPI_FLASH_FAST_READ_EN and addr 000001 → 8 dummy clocks then 0x22.
- Raise cs_n after 12 address bits, then issue 0x03 000000 → 0x11 (no stale state). Assert reset mid-DATA → o_miso=0, o_busy=0, o_last_cmd=0x00 the next clk.
- During a READ stream at addr 0x0004, backdoor-write 0x04=0xEE on the prefetch cycle → 0x55 returned; re-read → 0xEE.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash responder: READ (0x03), JEDEC ID (0x9F), READ STATUS (0x05)
// from a backdoor-loaded byte memory. Define SPI_FLASH_FAST_READ_EN to add FAST READ (0x0B).
module spi_flash_responder #(
  parameter int          MEM_AW   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic              i_wr_en,
  input  logic [MEM_AW-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  output logic              o_busy,
  output logic [7:0]        o_last_cmd,
  output logic              o_bad_cmd
);

  localparam int SH_W = (MEM_AW > 8) ? MEM_AW - 1 : 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_ID     = 3'd4,
    S_STAT   = 3'd5,
    S_IGNORE = 3'd6
`ifdef SPI_FLASH_FAST_READ_EN
    , S_DUMMY = 3'd7
`endif
  } state_t;

  state_t            r_state, w_state_nxt, w_cmd_dest;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic              r_cs_s1, r_cs_s2, r_cs_d;
  logic              r_mosi_s1, r_mosi_s2;
  logic              w_rise, w_fall, w_cs_fall, w_cs_hi;
  logic [SH_W-1:0]   r_sh_in;
  logic [7:0]        r_sh_out;
  logic [4:0]        r_bit_cnt;
  logic [MEM_AW-1:0] r_addr;
  logic              r_rd_en;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_mem [0:(1<<MEM_AW)-1];
  logic              r_miso, w_miso_nxt;
  logic [7:0]        r_last_cmd;
  logic              r_bad_cmd;
  logic              w_cmd_known, w_cmd_done, w_addr_done;
  logic [7:0]        w_cmd_byte;
  logic [MEM_AW-1:0] w_addr_cap;
`ifdef SPI_FLASH_FAST_READ_EN
  logic              r_fast;
  logic              w_dummy_done;
`endif

  // Input synchronisers; they settle within a few clocks so carry no reset.
  always_ff @(posedge clk) begin
    r_sclk_s1 <= i_sclk;
    r_sclk_s2 <= r_sclk_s1;
    r_sclk_d  <= r_sclk_s2;
    r_cs_s1   <= i_cs_n;
    r_cs_s2   <= r_cs_s1;
    r_cs_d    <= r_cs_s2;
    r_mosi_s1 <= i_mosi;
    r_mosi_s2 <= r_mosi_s1;
  end

  assign w_rise     = r_sclk_s2 & ~r_sclk_d;
  assign w_fall     = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall  = r_cs_d & ~r_cs_s2;
  assign w_cs_hi    = r_cs_s2;
  assign w_cmd_byte = {r_sh_in[6:0], r_mosi_s2};
  assign w_addr_cap = {r_sh_in[MEM_AW-2:0], r_mosi_s2};
  assign w_cmd_done  = (r_state == S_CMD)  && w_rise && (r_bit_cnt == 5'd7)  && !w_cs_hi;
  assign w_addr_done = (r_state == S_ADDR) && w_rise && (r_bit_cnt == 5'd23) && !w_cs_hi;
`ifdef SPI_FLASH_FAST_READ_EN
  assign w_dummy_done = (r_state == S_DUMMY) && w_rise && (r_bit_cnt == 5'd7) && !w_cs_hi;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and command decode
  always_comb begin
    w_cmd_known = 1'b1;
    case (w_cmd_byte)
      8'h03:   w_cmd_dest = S_ADDR;
      8'h9F:   w_cmd_dest = S_ID;
      8'h05:   w_cmd_dest = S_STAT;
`ifdef SPI_FLASH_FAST_READ_EN
      8'h0B:   w_cmd_dest = S_ADDR;
`endif
      default: begin
        w_cmd_dest  = S_IGNORE;
        w_cmd_known = 1'b0;
      end
    endcase

    w_state_nxt = r_state;
    if (r_state != S_IDLE && w_cs_hi) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD:  if (w_cmd_done) w_state_nxt = w_cmd_dest;
`ifdef SPI_FLASH_FAST_READ_EN
        S_ADDR:  if (w_addr_done) w_state_nxt = r_fast ? S_DUMMY : S_DATA;
        S_DUMMY: if (w_dummy_done) w_state_nxt = S_DATA;
`else
        S_ADDR: if (w_addr_done) w_state_nxt = S_DATA;
`endif
        default: ;
      endcase
    end
  end

  // FSM outputs: busy flag and next MISO bit
  always_comb begin
    o_busy     = (r_state != S_IDLE);
    w_miso_nxt = 1'b0;
    if (!w_cs_hi) begin
      case (r_state)
        S_DATA: begin
          w_miso_nxt = r_miso;
          if (w_fall) w_miso_nxt = (r_bit_cnt == 5'd0) ? r_rd_data[7] : r_sh_out[7];
        end
        S_ID: begin
          w_miso_nxt = r_miso;
          if (w_fall) w_miso_nxt = (r_bit_cnt < 5'd24) ? JEDEC_ID[5'd23 - r_bit_cnt] : 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Control registers: counters, address, read strobe, status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= 5'd0;
      r_addr     <= '0;
      r_rd_en    <= 1'b0;
      r_miso     <= 1'b0;
      r_last_cmd <= 8'h00;
      r_bad_cmd  <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      r_fast     <= 1'b0;
`endif
    end else begin
      r_miso    <= w_miso_nxt;
      r_bad_cmd <= w_cmd_done && !w_cmd_known;
      r_rd_en   <= 1'b0;
      if (w_cmd_done) r_last_cmd <= w_cmd_byte;
`ifdef SPI_FLASH_FAST_READ_EN
      if (w_cmd_done) r_fast <= (w_cmd_byte == 8'h0B);
`endif
      if (r_state == S_IDLE || w_cs_hi) begin
        r_bit_cnt <= 5'd0;
      end else begin
        case (r_state)
          S_CMD: if (w_rise) r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
          S_ADDR: if (w_rise) begin
            if (r_bit_cnt == 5'd23) begin
              r_bit_cnt <= 5'd0;
              r_addr    <= w_addr_cap;
`ifdef SPI_FLASH_FAST_READ_EN
              r_rd_en   <= !r_fast;
`else
              r_rd_en   <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
`ifdef SPI_FLASH_FAST_READ_EN
          S_DUMMY: if (w_rise) begin
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              r_rd_en   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
`endif
          S_DATA: if (w_fall) begin
            // Last bit of the byte is going out: advance and prefetch the next byte.
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              r_addr    <= r_addr + MEM_AW'(1);
              r_rd_en   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          S_ID: if (w_fall && r_bit_cnt != 5'd24) r_bit_cnt <= r_bit_cnt + 5'd1;
          default: ;
        endcase
      end
    end
  end

  // Datapath: shift registers and read-first memory
  always_ff @(posedge clk) begin
    if (w_rise) r_sh_in <= {r_sh_in[SH_W-2:0], r_mosi_s2};
    if (r_state == S_DATA && w_fall) begin
      if (r_bit_cnt == 5'd0) r_sh_out <= {r_rd_data[6:0], 1'b0};
      else                   r_sh_out <= {r_sh_out[6:0], 1'b0};
    end
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (r_rd_en) r_rd_data <= r_mem[r_addr];
  end

  assign o_miso     = r_miso;
  assign o_last_cmd = r_last_cmd;
  assign o_bad_cmd  = r_bad_cmd;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: the bench acts as an SPI master with an
// 8-clk sclk period and checks returned bytes and status outputs against fixed values.
module tb_spi_flash_responder;

  logic        clk;
  logic        reset;
  logic        i_sclk;
  logic        i_cs_n;
  logic        i_mosi;
  logic        o_miso;
  logic        i_wr_en;
  logic [15:0] i_wr_addr;
  logic [7:0]  i_wr_data;
  logic        o_busy;
  logic [7:0]  o_last_cmd;
  logic        o_bad_cmd;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          bad_cnt  = 0;
  int          bad_base;
  logic [15:0] inj_addr;
  logic [7:0]  inj_data;
  logic [7:0]  rx;

  spi_flash_responder #(.MEM_AW(16), .JEDEC_ID(24'hEF4016)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_sclk     (i_sclk),
    .i_cs_n     (i_cs_n),
    .i_mosi     (i_mosi),
    .o_miso     (o_miso),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .o_busy     (o_busy),
    .o_last_cmd (o_last_cmd),
    .o_bad_cmd  (o_bad_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_bad_cmd === 1'b1) bad_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  // One SPI bit: fall, wait, sample MISO, rise; optional backdoor write timed
  // to land on the clk edge where the first byte read is issued.
  task automatic spi_bit(input logic b, input logic inj, output logic rxb);
    i_sclk = 1'b0; i_mosi = b;
    repeat (4) @(negedge clk);
    rxb = o_miso;
    i_sclk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2 && inj) begin
        i_wr_addr = inj_addr; i_wr_data = inj_data; i_wr_en = 1'b1;
      end
      if (i == 3) i_wr_en = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic inj_last, output logic [7:0] rxd);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], inj_last && (i == 0), b);
      rxd[i] = b;
    end
  endtask

  task automatic spi_start(input logic [7:0] cmd, input logic [23:0] addr, input logic inj);
    logic [7:0] dummy;
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(cmd, 1'b0, dummy);
    spi_byte(addr[23:16], 1'b0, dummy);
    spi_byte(addr[15:8], 1'b0, dummy);
    spi_byte(addr[7:0], inj, dummy);
  endtask

  task automatic cs_high();
    i_sclk = 1'b0;
    repeat (4) @(negedge clk);
    i_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    repeat (5) @(negedge clk);
    check("reset miso", o_miso, 0);
    check("reset busy", o_busy, 0);
    check("reset last_cmd", o_last_cmd, 8'h00);
    check("reset bad_cmd", o_bad_cmd, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) mem_write(16'(i), 8'((i + 1) * 8'h11));

    // READ from 0x000002, three bytes
    bad_base = bad_cnt;
    spi_start(8'h03, 24'h000002, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("read2 byte0", rx, 8'h33);
    spi_byte(8'h00, 1'b0, rx); check("read2 byte1", rx, 8'h44);
    spi_byte(8'h00, 1'b0, rx); check("read2 byte2", rx, 8'h55);
    check("read2 last_cmd", o_last_cmd, 8'h03);
    check("read2 busy", o_busy, 1);
    check("read2 no bad_cmd", bad_cnt - bad_base, 0);
    i_sclk = 1'b0;
    repeat (4) @(negedge clk);
    i_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("busy cs+2", o_busy, 1);
    @(negedge clk);
    check("busy cs+3", o_busy, 0);
    check("miso after cs", o_miso, 0);
    repeat (3) @(negedge clk);

    // Address wrap and truncation
    mem_write(16'hFFFF, 8'hA5);
    mem_write(16'h0000, 8'h5A);
    spi_start(8'h03, 24'h00FFFF, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("wrap byte0", rx, 8'hA5);
    spi_byte(8'h00, 1'b0, rx); check("wrap byte1", rx, 8'h5A);
    cs_high();
    spi_start(8'h03, 24'h01FFFF, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("trunc byte0", rx, 8'hA5);
    cs_high();

    // JEDEC ID
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h9F, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx); check("id byte0", rx, 8'hEF);
    spi_byte(8'h00, 1'b0, rx); check("id byte1", rx, 8'h40);
    spi_byte(8'h00, 1'b0, rx); check("id byte2", rx, 8'h16);
    spi_byte(8'h00, 1'b0, rx); check("id byte3", rx, 8'h00);
    check("id last_cmd", o_last_cmd, 8'h9F);
    cs_high();

    // READ STATUS
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h05, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx); check("stat byte0", rx, 8'h00);
    spi_byte(8'h00, 1'b0, rx); check("stat byte1", rx, 8'h00);
    check("stat last_cmd", o_last_cmd, 8'h05);
    cs_high();

`ifdef SPI_FLASH_FAST_READ_EN
    bad_base = bad_cnt;
    spi_start(8'h0B, 24'h000001, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("fast dummy miso", rx, 8'h00);
    spi_byte(8'h00, 1'b0, rx); check("fast byte0", rx, 8'h22);
    check("fast no bad_cmd", bad_cnt - bad_base, 0);
    check("fast last_cmd", o_last_cmd, 8'h0B);
    cs_high();
`else
    bad_base = bad_cnt;
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h0B, 1'b0, rx);
    spi_byte(8'hFF, 1'b0, rx); check("0B miso", rx, 8'h00);
    check("0B bad_cmd cycles", bad_cnt - bad_base, 1);
    check("0B last_cmd", o_last_cmd, 8'h0B);
    cs_high();
`endif

    // Abort after 12 address bits, then a clean READ from 0
    mem_write(16'h0000, 8'h11);
    i_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h03, 1'b0, rx);
    spi_byte(8'hFF, 1'b0, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, rx[0]);
    cs_high();
    spi_start(8'h03, 24'h000000, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("abort reread", rx, 8'h11);
    cs_high();

    // Backdoor write on the read-issue cycle: old byte returned, then new one
    inj_addr = 16'h0004; inj_data = 8'hEE;
    spi_start(8'h03, 24'h000004, 1'b1);
    spi_byte(8'h00, 1'b0, rx); check("rw same cycle old", rx, 8'h55);
    cs_high();
    spi_start(8'h03, 24'h000004, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("rw reread new", rx, 8'hEE);
    cs_high();

    // Reset in the middle of a data byte
    spi_start(8'h03, 24'h00FFFF, 1'b0);
    i_sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset miso", o_miso, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset miso", o_miso, 0);
    check("midreset busy", o_busy, 0);
    check("midreset last_cmd", o_last_cmd, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset idle with cs low", o_busy, 0);
    i_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_start(8'h03, 24'h000001, 1'b0);
    spi_byte(8'h00, 1'b0, rx); check("post-reset read", rx, 8'h22);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
